// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the iterative divider and its EX-stage users.
//   div_state_t          : FSM state encoding (2 bits)
//   DIV_Q_HI .. DIV_R_LO : result field positions for WIDTH=32;
//                          EX slices {quotient, remainder} with these.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam int DIV_Q_HI = 63;
    localparam int DIV_Q_LO = 32;
    localparam int DIV_R_HI = 31;
    localparam int DIV_R_LO = 0;

endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: combinational conditional negate for a pair of operands.
// The divider uses one instance to take magnitudes at the input (neg = sign
// bit) and one to apply the result signs at the output (neg = q_neg / r_neg).
// With SIGNED=0 both values pass through untouched.
//   a, b         : operands in
//   neg_a, neg_b : negate request per operand
//   y_a, y_b     : operands out
module div_sign_fix #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             neg_a,
    input  logic             neg_b,
    output logic [WIDTH-1:0] y_a,
    output logic [WIDTH-1:0] y_b
);

    always_comb begin
        y_a = (SIGNED && neg_a) ? -a : a;
        y_b = (SIGNED && neg_b) ? -b : b;
    end

endmodule

// File: rtl/iter_div.sv
// iter_div: multi-cycle radix-2 restoring divider with valid/ready channels.
//   clk, rst                         : clock, async active-high reset
//   s_axis_dividend_t{valid,ready,data}: dividend channel
//   s_axis_divisor_t{valid,ready,data} : divisor channel
//   m_axis_dout_t{valid,ready,data}    : result {quotient, remainder}
// Both operands are taken together in IDLE; WIDTH+1 CALC cycles later the
// result is registered and held in DONE until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a new operand pair
// CALC  | one shift/subtract step per cycle, last cycle registers result
// DONE  | result valid, waiting for dout_tready
module iter_div
    import div_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    output logic               m_axis_dout_tvalid,
    input  logic               m_axis_dout_tready,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t         state, state_nxt;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   dvd_raw;
    logic [CW-1:0]      cnt;
    logic               q_neg, r_neg, dz;
    logic [2*WIDTH-1:0] dout;

    logic               accept;
    logic [WIDTH-1:0]   dvd_abs, dvs_abs;
    logic [WIDTH-1:0]   q_fix, r_fix;
    logic [WIDTH+1:0]   sh, diff;
    logic               borrow;

    assign accept = (state == DIV_IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

    div_sign_fix #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_fix_in (
        .a     (s_axis_dividend_tdata),
        .b     (s_axis_divisor_tdata),
        .neg_a (s_axis_dividend_tdata[WIDTH-1]),
        .neg_b (s_axis_divisor_tdata[WIDTH-1]),
        .y_a   (dvd_abs),
        .y_b   (dvs_abs)
    );

    div_sign_fix #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_fix_out (
        .a     (quo),
        .b     (rem[WIDTH-1:0]),
        .neg_a (q_neg),
        .neg_b (r_neg),
        .y_a   (q_fix),
        .y_b   (r_fix)
    );

    // Partial remainder stays below the divisor, so rem[WIDTH] is always 0
    // and the extra top bit of sh/diff only carries the borrow.
    always_comb begin
        sh     = {rem, quo[WIDTH-1]};
        diff   = sh - {2'b00, dvs};
        borrow = diff[WIDTH+1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (accept)             state_nxt = DIV_CALC;
            DIV_CALC: if (cnt == '0)          state_nxt = DIV_DONE;
            DIV_DONE: if (m_axis_dout_tready) state_nxt = DIV_IDLE;
            default:                          state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            dvd_raw <= '0;
            cnt     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dz      <= 1'b0;
            dout    <= '0;
        end else if (accept) begin
            rem     <= '0;
            quo     <= dvd_abs;
            dvs     <= dvs_abs;
            dvd_raw <= s_axis_dividend_tdata;
            cnt     <= CW'(WIDTH);
            q_neg   <= SIGNED ? (s_axis_dividend_tdata[WIDTH-1] ^ s_axis_divisor_tdata[WIDTH-1]) : 1'b0;
            r_neg   <= SIGNED ? s_axis_dividend_tdata[WIDTH-1] : 1'b0;
            dz      <= (s_axis_divisor_tdata == '0);
        end else if (state == DIV_CALC) begin
            if (cnt != '0) begin
                rem <= borrow ? sh[WIDTH:0] : diff[WIDTH:0];
                quo <= {quo[WIDTH-2:0], ~borrow};
                cnt <= cnt - CW'(1);
            end else begin
                // Divide-by-zero reports the raw dividend with no sign fix-up.
                dout <= dz ? {{WIDTH{1'b1}}, dvd_raw} : {q_fix, r_fix};
            end
        end
    end

    assign s_axis_dividend_tready = (state == DIV_IDLE);
    assign s_axis_divisor_tready  = (state == DIV_IDLE);
    assign m_axis_dout_tvalid     = (state == DIV_DONE);
    assign m_axis_dout_tdata      = dout;

endmodule

// File: tb/tb_iter_div.sv
module tb_iter_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  dvd_valid = '0, dvs_valid = '0, out_rdy = 2'b11;
    logic [1:0]  dvd_rdy, dvs_rdy, out_valid;
    logic [31:0] dvd_data [2];
    logic [31:0] dvs_data [2];
    logic [63:0] dout [2];

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb [$];

    typedef struct {
        int          mode;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [63:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    // index 0: unsigned instance, index 1: signed instance
    iter_div #(.WIDTH(32), .SIGNED(1'b0)) u_div_u (
        .clk(clk), .rst(rst),
        .s_axis_dividend_tvalid(dvd_valid[0]), .s_axis_dividend_tready(dvd_rdy[0]),
        .s_axis_dividend_tdata(dvd_data[0]),
        .s_axis_divisor_tvalid(dvs_valid[0]), .s_axis_divisor_tready(dvs_rdy[0]),
        .s_axis_divisor_tdata(dvs_data[0]),
        .m_axis_dout_tvalid(out_valid[0]), .m_axis_dout_tready(out_rdy[0]),
        .m_axis_dout_tdata(dout[0])
    );

    iter_div #(.WIDTH(32), .SIGNED(1'b1)) u_div_s (
        .clk(clk), .rst(rst),
        .s_axis_dividend_tvalid(dvd_valid[1]), .s_axis_dividend_tready(dvd_rdy[1]),
        .s_axis_dividend_tdata(dvd_data[1]),
        .s_axis_divisor_tvalid(dvs_valid[1]), .s_axis_divisor_tready(dvs_rdy[1]),
        .s_axis_divisor_tdata(dvs_data[1]),
        .m_axis_dout_tvalid(out_valid[1]), .m_axis_dout_tready(out_rdy[1]),
        .m_axis_dout_tdata(dout[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic accept(input int m, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        @(negedge clk);
        dvd_data[m] = a; dvs_data[m] = b;
        dvd_valid[m] = 1'b1; dvs_valid[m] = 1'b1;
        chk("ready_before_accept", {62'd0, dvd_rdy[m], dvs_rdy[m]}, 64'd3);
        @(posedge clk); #1;
        sb.push_back(exp);
        dvd_valid[m] = 1'b0; dvs_valid[m] = 1'b0;
        chk("ready_after_accept", {62'd0, dvd_rdy[m], dvs_rdy[m]}, 64'd0);
    endtask

    // Call right after the acceptance edge (+#1); handshakes if out_rdy is high.
    task automatic collect(input int m);
        int n = 0;
        logic [63:0] exp;
        while (!out_valid[m] && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 64'(n), 64'd33);
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        chk("tdata", dout[m], exp);
        if (out_rdy[m]) begin
            @(posedge clk); #1;
            chk("idle_after_handshake", {62'd0, out_valid[m], dvd_rdy[m]}, 64'd1);
        end
    endtask

    initial begin
        vec_t vecs [$];
        logic [63:0] held;
        logic [31:0] ra, rb;

        vecs.push_back('{0, 32'd100,        32'd7,        64'h0000000E_00000002});
        vecs.push_back('{1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFD_FFFFFFFF});
        vecs.push_back('{1, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000});
        vecs.push_back('{1, 32'd5,          32'd0,        64'hFFFFFFFF_00000005});
        vecs.push_back('{0, 32'd5,          32'd0,        64'hFFFFFFFF_00000005});
        vecs.push_back('{1, 32'hFFFFFFFB,   32'd0,        64'hFFFFFFFF_FFFFFFFB});
        vecs.push_back('{0, 32'hFFFFFFFF,   32'd1,        64'hFFFFFFFF_00000000});
        vecs.push_back('{1, 32'd7,          32'hFFFFFFFE, 64'hFFFFFFFD_00000001});
        vecs.push_back('{1, 32'hFFFFFF9C,   32'hFFFFFFF9, 64'h0000000E_FFFFFFFE});
        vecs.push_back('{0, 32'h80000000,   32'h10,       64'h08000000_00000000});
        vecs.push_back('{0, 32'd12345,      32'd12345,    64'h00000001_00000000});
        vecs.push_back('{0, 32'd3,          32'd10,       64'h00000000_00000003});
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = 32'($urandom_range(1, 1000));
            vecs.push_back('{0, ra, rb, {ra / rb, ra % rb}});
        end

        for (int m = 0; m < 2; m++) begin
            dvd_data[m] = '0; dvs_data[m] = '0;
        end

        // reset held
        #12;
        for (int m = 0; m < 2; m++) begin
            chk("rst_ready", {62'd0, dvd_rdy[m], dvs_rdy[m]}, 64'd3);
            chk("rst_tvalid", {63'd0, out_valid[m]}, 64'd0);
            chk("rst_tdata", dout[m], 64'd0);
        end
        @(negedge clk); rst = 1'b0;

        foreach (vecs[i]) begin
            accept(vecs[i].mode, vecs[i].dvd, vecs[i].dvs, vecs[i].exp);
            collect(vecs[i].mode);
        end

        // only dividend valid for 5 cycles, then both
        @(negedge clk);
        dvd_data[0] = 32'd100; dvs_data[0] = 32'd7;
        dvd_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("single_valid_not_taken", {63'd0, dvd_rdy[0]}, 64'd1);
        end
        @(negedge clk); dvs_valid[0] = 1'b1;
        @(posedge clk); #1;
        sb.push_back(64'h0000000E_00000002);
        chk("both_valid_taken", {63'd0, dvd_rdy[0]}, 64'd0);
        dvd_valid[0] = 1'b0; dvs_valid[0] = 1'b0;
        dvd_data[0] = 32'd1; dvs_data[0] = 32'd1;
        collect(0);

        // back-pressure with new requests pending
        out_rdy[1] = 1'b0;
        accept(1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFD_FFFFFFFF);
        collect(1);
        held = dout[1];
        dvd_data[1] = 32'd9; dvs_data[1] = 32'd3;
        dvd_valid[1] = 1'b1; dvs_valid[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_tvalid", {63'd0, out_valid[1]}, 64'd1);
            chk("stall_tdata", dout[1], held);
            chk("stall_ready", {62'd0, dvd_rdy[1], dvs_rdy[1]}, 64'd0);
        end
        @(negedge clk);
        dvd_valid[1] = 1'b0; dvs_valid[1] = 1'b0;
        out_rdy[1] = 1'b1;
        @(posedge clk); #1;
        chk("release_idle", {62'd0, out_valid[1], dvd_rdy[1]}, 64'd1);

        // async reset mid-CALC
        accept(0, 32'd100, 32'd7, 64'h0000000E_00000002);
        repeat (14) @(posedge clk);
        @(negedge clk); rst = 1'b1; #1;
        chk("abort_calc_tvalid", {63'd0, out_valid[0]}, 64'd0);
        chk("abort_calc_tdata", dout[0], 64'd0);
        chk("abort_calc_ready", {62'd0, dvd_rdy[0], dvs_rdy[0]}, 64'd3);
        sb.delete();
        @(negedge clk); rst = 1'b0;
        accept(0, 32'd20, 32'd3, 64'h00000006_00000002);
        collect(0);

        // async reset mid-DONE
        out_rdy[0] = 1'b0;
        accept(0, 32'd50, 32'd8, 64'h00000006_00000002);
        collect(0);
        @(negedge clk); rst = 1'b1; #1;
        chk("abort_done_tvalid", {63'd0, out_valid[0]}, 64'd0);
        chk("abort_done_tdata", dout[0], 64'd0);
        chk("abort_done_ready", {63'd0, dvd_rdy[0]}, 64'd1);
        @(negedge clk); rst = 1'b0; out_rdy[0] = 1'b1;
        accept(1, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000);
        collect(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
